// File: rtl/wb_regfile8.sv
// wb_regfile8 -- write-back stage behind the 8-bit shifter.
// The shifter result is captured into a one-entry staging register and then
// committed into a small register file on the following edge. The zero and
// negative flags are updated from each committed value. Two combinational read
// ports feed the ALU operands.
//
// Build option: define WB_BYPASS_EN to forward the staged value to a read
// that addresses the pending register. With forwarding, hazard is tied low.
// Without it, hazard tells the controller to stall for one cycle.
module wb_regfile8 #(
   parameter int DATA_W   = 8,
   parameter int NUM_REGS = 4,
   parameter int ADDR_W   = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] from_shifter,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic              clr_all,
   input  logic [ADDR_W-1:0] rd_a_addr,
   input  logic [ADDR_W-1:0] rd_b_addr,
   output logic [DATA_W-1:0] rd_a_data,
   output logic [DATA_W-1:0] rd_b_data,
   output logic              zero_flag,
   output logic              neg_flag,
   output logic              wb_pending,
   output logic              hazard
);

   // Every read index must land inside the array. For that to hold, the
   // address width has to cover the register count exactly.
   if (NUM_REGS < 2 || NUM_REGS > 16 || (1 << ADDR_W) != NUM_REGS) begin : g_param_check
      $error("wb_regfile8: NUM_REGS must be a power of two in 2..16 and equal 2**ADDR_W");
   end

   // A write is either idle or staged and waiting to commit on the next edge.
   typedef enum logic {
      IDLE   = 1'b0,
      STAGED = 1'b1
   } wb_state_t;

   wb_state_t         state_q;
   wb_state_t         state_d;
   logic [DATA_W-1:0] stage_data;
   logic [ADDR_W-1:0] stage_addr;
   logic [DATA_W-1:0] regs [NUM_REGS];
   logic              commit_en;
   logic              capture_en;

   // State register for the staging pipeline.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments. Every flop then
      // samples its inputs as they stood before this edge, in any block order.
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   // Next-state logic. clr_all drops the commit and the capture at the same edge.
   always_comb begin
      // NOTE: each output gets a default before any branch. A path that does
      // not assign a signal cannot then infer a latch.
      state_d    = IDLE;
      commit_en  = 1'b0;
      capture_en = 1'b0;
      if (clr_all) begin
         state_d = IDLE;
      end else begin
         commit_en  = (state_q == STAGED);
         capture_en = wr_en;
         state_d    = wr_en ? STAGED : IDLE;
      end
   end

   assign wb_pending = (state_q == STAGED);

   // Staging register. It loads on capture and keeps its value otherwise.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stage_data <= '0;
         stage_addr <= '0;
      end else if (clr_all) begin
         stage_data <= '0;
         stage_addr <= '0;
      end else if (capture_en) begin
         stage_data <= from_shifter;
         stage_addr <= wr_addr;
      end
   end

   // Register file. A commit writes the staged value into its slot.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: this array is built from flops, not RAM, and the read ports
         // drive the ALU directly. It is reset so that no X reaches the
         // operands after reset.
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (clr_all) begin
         for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      end else if (commit_en) begin
         regs[stage_addr] <= stage_data;
      end
   end

   // Status flags. They follow each committed value and hold between commits.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         zero_flag <= 1'b0;
         neg_flag  <= 1'b0;
      end else if (clr_all) begin
         zero_flag <= 1'b0;
         neg_flag  <= 1'b0;
      end else if (commit_en) begin
         zero_flag <= (stage_data == '0);
         neg_flag  <= stage_data[DATA_W-1];
      end
   end

`ifdef WB_BYPASS_EN
   // Read ports with forwarding. A read of the pending slot sees the staged value.
   always_comb begin
      rd_a_data = regs[rd_a_addr];
      rd_b_data = regs[rd_b_addr];
      if (wb_pending && (rd_a_addr == stage_addr)) rd_a_data = stage_data;
      if (wb_pending && (rd_b_addr == stage_addr)) rd_b_data = stage_data;
   end

   assign hazard = 1'b0;
`else
   // Read ports without forwarding. They always return the array contents.
   always_comb begin
      rd_a_data = regs[rd_a_addr];
      rd_b_data = regs[rd_b_addr];
   end

   assign hazard = wb_pending && ((rd_a_addr == stage_addr) || (rd_b_addr == stage_addr));
`endif

endmodule

// File: doc/wb_regfile8.md
Name: wb_regfile8

Overview:
- Write-back stage directly downstream of the 8-bit shifter.
- Captures the shifter's bus result into a small general-purpose register file through a one-entry staging register.
- Updates zero/negative status flags when each write commits.
- Provides two asynchronous read ports that feed the ALU operand inputs.

Parameters:
- DATA_W, 8, width of every register and of the bus.
- NUM_REGS, 4, number of registers; power of two, 2..16.
- ADDR_W, 2, address width; must equal log2(NUM_REGS).

Ports:
- clk  input  1  single rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- from_shifter  input  DATA_W  result bus from the shifter.
- wr_en  input  1  capture from_shifter this cycle.
- wr_addr  input  ADDR_W  destination register.
- clr_all  input  1  synchronous clear of the file, staging register and flags.
- rd_a_addr  input  ADDR_W  read port A address.
- rd_b_addr  input  ADDR_W  read port B address.
- rd_a_data  output  DATA_W  read port A data, combinational.
- rd_b_data  output  DATA_W  read port B data, combinational.
- zero_flag  output  1  last committed value was 0.
- neg_flag  output  1  MSB of last committed value.
- wb_pending  output  1  staging register holds an uncommitted write.
- hazard  output  1  a read address matches the pending write address.

Behaviour:
- Reset (rst_n low, asynchronous): all registers, stage_data, stage_addr, wb_pending, zero_flag and neg_flag go to 0. Effect is immediate, including mid-write; an in-flight staged write is discarded.
- Two-state pipeline per write, IDLE and STAGED, represented by wb_pending.
- Capture: edge N with wr_en=1 loads stage_data<=from_shifter, stage_addr<=wr_addr, wb_pending<=1.
- Commit: at edge N+1, if wb_pending=1:
  - reg[stage_addr]<=stage_data.
  - zero_flag<=(stage_data==0).
  - neg_flag<=stage_data[DATA_W-1].
- End of commit: wb_pending<=wr_en at that same edge. Back-to-back writes stream one per cycle with no bubbles. Commit latency is fixed at 2 edges from wr_en.
- Commit ordering: consecutive writes to the same address commit in issue order; the last one wins.
- Flags hold their value on cycles with no commit.
- clr_all=1 at an edge:
  - All registers, flags and wb_pending go to 0.
  - clr_all wins over a simultaneous commit and over a simultaneous capture; both are dropped.
- Read ports with no match against a pending write: rd_x_data = reg[rd_x_addr], purely combinational.
- hazard = wb_pending && (rd_a_addr==stage_addr || rd_b_addr==stage_addr).
- Both read ports may address the same register; each returns the same value.
- wr_addr is always in range by construction (ADDR_W bits); no bounds checking.
- No X propagation: outputs are defined whenever rst_n has been asserted once.

Optional Feature:
- Macro: WB_BYPASS_EN.
- Defined:
  - A read whose address equals stage_addr while wb_pending=1 returns stage_data (forwarding), not the stale array value.
  - hazard is tied to 0.
- Undefined:
  - Reads always return the array contents.
  - hazard behaves as specified in Behaviour; the controller must stall one cycle on hazard.
- Register, flag and commit timing are identical in both builds.

Test Plan:
- Reset mid-write: wr_en=1, wr_addr=2, from_shifter=8'hA5, then pulse rst_n low before the commit edge. Required: reg2=0, wb_pending=0, zero_flag=0, neg_flag=0.
- Basic write/commit:
  - Write 8'h80 to reg1 at edge N.
  - After edge N: wb_pending=1.
  - After edge N+1: rd_a_addr=1 gives rd_a_data=8'h80, neg_flag=1, zero_flag=0.
- Back-to-back same address: writes 8'h00, then 8'h3C, to reg3 on consecutive cycles. Required:
  - Commits in order.
  - Final reg3=8'h3C.
  - zero_flag=1 after the first commit, then 0 after the second.
- Hazard/bypass: write 8'h55 to reg0 and read rd_b_addr=0 in the following cycle.
  - Without WB_BYPASS_EN: hazard=1, rd_b_data=old value.
  - With WB_BYPASS_EN: hazard=0, rd_b_data=8'h55.
- clr_all collision: assert clr_all on the same edge as a pending commit of 8'hFF to reg2 and a new capture. Required: all registers 0, flags 0, wb_pending=0.
- Sweep: write 8'h01<<k to reg k for k=0..NUM_REGS-1, then read all pairs on A/B. Required: every read matches the written value, and A and B agree on a common address.
